// File: rtl/uart_program_loader.sv
// UART boot loader: receives an 8N1 program image and writes 32-bit words
// into instruction memory, holding the CPU in reset until the load is done.
module uart_program_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          MAX_WORDS    = 256,
  parameter logic [31:0] ADDR_BASE    = 32'h0
) (
  input  logic        CLK_IN,
  input  logic        GLOBALRESET,
  input  logic        rx_in,
  output logic        imem_wr_en_out,
  output logic [31:0] imem_addr_out,
  output logic [31:0] imem_data_out,
  output logic        cpu_reset_out,
  output logic        done_out,
  output logic        err_out,
  output logic [15:0] word_count_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  typedef enum logic [2:0] {
    L_HDR_HI, L_HDR_LO, L_WORD, L_WRITE, L_DONE
  } ld_st_t;

  // [1:0] is the synchronizer, [2] the previous synchronized sample
  logic [2:0] sync_q;
  logic       rx_s, rx_prev;

  rx_st_t        rx_q, rx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;

  ld_st_t      ld_q, ld_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] wc_q, wc_d;
  logic        err_q, err_d;
  logic [15:0] hdr;

  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];
  assign hdr     = {n_q[15:8], sh_q};

  always_ff @(posedge CLK_IN or posedge GLOBALRESET) begin
    if (GLOBALRESET) begin
      sync_q <= 3'b111;
      rx_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      bv_q   <= 1'b0;
      fe_q   <= 1'b0;
      ld_q   <= L_HDR_HI;
      n_q    <= '0;
      idx_q  <= '0;
      bcnt_q <= '0;
      word_q <= '0;
      addr_q <= ADDR_BASE;
      data_q <= '0;
      wc_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], rx_in};
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      bv_q   <= bv_d;
      fe_q   <= fe_d;
      ld_q   <= ld_d;
      n_q    <= n_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
      word_q <= word_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wc_q   <= wc_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    rx_d  = rx_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    bv_d  = 1'b0;
    fe_d  = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) rx_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          rx_d  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          bv_d  = rx_s;
          fe_d  = !rx_s;
          rx_d  = RX_IDLE;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_d   = ld_q;
    n_d    = n_q;
    idx_d  = idx_q;
    bcnt_d = bcnt_q;
    word_d = word_q;
    addr_d = addr_q;
    data_d = data_q;
    wc_d   = wc_q;
    err_d  = err_q;
    if (fe_q && ld_q != L_DONE) begin
      err_d  = 1'b1;
      n_d    = '0;
      bcnt_d = '0;
      word_d = '0;
      ld_d   = L_HDR_HI;
    end else begin
      unique case (ld_q)
        L_HDR_HI: begin
          if (bv_q) begin
            n_d[15:8] = sh_q;
            ld_d      = L_HDR_LO;
          end
        end
        L_HDR_LO: begin
          if (bv_q) begin
            n_d[7:0] = sh_q;
            if (hdr == 16'd0) begin
              wc_d = '0;
              ld_d = L_DONE;
            end else if ({16'd0, hdr} > MAXW) begin
              err_d = 1'b1;
              ld_d  = L_HDR_HI;
            end else begin
              idx_d  = '0;
              bcnt_d = '0;
              wc_d   = '0;
              ld_d   = L_WORD;
            end
          end
        end
        L_WORD: begin
          if (bv_q) begin
            word_d = {word_q[23:0], sh_q};
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              data_d = {word_q[23:0], sh_q};
              addr_d = ADDR_BASE + {14'd0, idx_q, 2'b00};
              ld_d   = L_WRITE;
            end
          end
        end
        L_WRITE: begin
          idx_d = idx_q + 16'd1;
          wc_d  = wc_q + 16'd1;
          ld_d  = (idx_q + 16'd1 == n_q) ? L_DONE : L_WORD;
        end
        L_DONE:  ld_d = L_DONE;
        default: ld_d = L_HDR_HI;
      endcase
    end
  end

  always_comb begin
    imem_wr_en_out = (ld_q == L_WRITE);
    done_out       = (ld_q == L_DONE);
    cpu_reset_out  = (ld_q != L_DONE);
    imem_addr_out  = addr_q;
    imem_data_out  = data_q;
    err_out        = err_q;
    word_count_out = wc_q;
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: drives UART frames and compares strobes
// and status against a word-list reference model.
module tb_uart_program_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        wr;
  logic [31:0] addr, data;
  logic        cpu_rst, done, err;
  logic [15:0] wc;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .MAX_WORDS(256),
    .ADDR_BASE(32'h0)
  ) dut (
    .CLK_IN(clk),
    .GLOBALRESET(rst),
    .rx_in(rx),
    .imem_wr_en_out(wr),
    .imem_addr_out(addr),
    .imem_data_out(data),
    .cpu_reset_out(cpu_rst),
    .done_out(done),
    .err_out(err),
    .word_count_out(wc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] img_w[$];
  logic [7:0]  bytes_q[$];
  int          last_wr_cyc   = -1;
  int          done_rise_cyc = -1;
  bit          rst_mis       = 1'b0;
  logic        done_prev     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      got_a.push_back(addr);
      got_d.push_back(data);
      last_wr_cyc = cyc;
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
    if (cpu_rst !== ~done) rst_mis = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = !bad;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Reference image: 16-bit big-endian count, then big-endian words
  task automatic build();
    logic [15:0] n;
    n = 16'(img_w.size());
    bytes_q.delete();
    bytes_q.push_back(n[15:8]);
    bytes_q.push_back(n[7:0]);
    foreach (img_w[i]) begin
      bytes_q.push_back(img_w[i][31:24]);
      bytes_q.push_back(img_w[i][23:16]);
      bytes_q.push_back(img_w[i][15:8]);
      bytes_q.push_back(img_w[i][7:0]);
    end
  endtask

  task automatic send_all();
    foreach (bytes_q[i]) send_byte(bytes_q[i], 1'b0);
  endtask

  task automatic rand_words(input int n);
    img_w.delete();
    repeat (n) img_w.push_back($urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 2000 && done !== 1'b1; k++) @(negedge clk);
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    got_a.delete();
    got_d.delete();
    last_wr_cyc   = -1;
    done_rise_cyc = -1;
    rst_mis       = 1'b0;
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_wr"},   {31'd0, wr}, 32'd0);
    chk({p, "_addr"}, addr, 32'h0);
    chk({p, "_data"}, data, 32'h0);
    chk({p, "_cpurst"}, {31'd0, cpu_rst}, 32'd1);
    chk({p, "_done"}, {31'd0, done}, 32'd0);
    chk({p, "_err"},  {31'd0, err}, 32'd0);
    chk({p, "_wc"},   {16'd0, wc}, 32'd0);
  endtask

  // Expected strobes: word i of the image lands at byte address 4*i
  task automatic check_load(input string p, input logic exp_err);
    int n;
    n = img_w.size();
    chk({p, "_nwr"}, 32'(got_a.size()), 32'(n));
    for (int i = 0; i < n && i < got_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", p, i), got_a[i], 32'(4 * i));
      chk($sformatf("%s_data%0d", p, i), got_d[i], img_w[i]);
    end
    chk({p, "_done"}, {31'd0, done}, 32'd1);
    chk({p, "_cpurst"}, {31'd0, cpu_rst}, 32'd0);
    chk({p, "_wc"}, {16'd0, wc}, 32'(n));
    chk({p, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({p, "_rstmis"}, {31'd0, rst_mis}, 32'd0);
    if (n > 0) begin
      chk({p, "_donecyc"}, 32'(done_rise_cyc), 32'(last_wr_cyc + 1));
      chk({p, "_addrhold"}, addr, 32'(4 * (n - 1)));
      chk({p, "_datahold"}, data, img_w[n-1]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_reset_vals("por");
    do_reset();
    check_reset_vals("rst");

    img_w = '{32'h20020005, 32'h0000000C};
    build();
    send_all();
    wait_done();
    check_load("normal", 1'b0);
    repeat (4) send_byte(8'($urandom), 1'b0);
    chk("post_done_nwr", 32'(got_a.size()), 32'd2);
    chk("post_done_wc", {16'd0, wc}, 32'd2);

    for (int r = 0; r < 3; r++) begin
      do_reset();
      rand_words(int'($urandom_range(1, 5)));
      build();
      send_all();
      wait_done();
      check_load($sformatf("rand%0d", r), 1'b0);
    end

    do_reset();
    img_w.delete();
    build();
    send_byte(bytes_q[0], 1'b0);
    chk("empty_mid_done", {31'd0, done}, 32'd0);
    send_byte(bytes_q[1], 1'b0);
    check_load("empty", 1'b0);

    do_reset();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_done", {31'd0, done}, 32'd0);
    img_w = '{32'h20020005, 32'h0000000C};
    build();
    send_all();
    wait_done();
    check_load("glitch", 1'b0);

    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h02, 1'b1);
    repeat (4 * CPB) @(negedge clk);
    chk("frame_err", {31'd0, err}, 32'd1);
    chk("frame_nwr", 32'(got_a.size()), 32'd0);
    chk("frame_done", {31'd0, done}, 32'd0);
    rand_words(2);
    build();
    send_all();
    wait_done();
    check_load("frame_reload", 1'b1);

    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_nwr", 32'(got_a.size()), 32'd0);
    chk("over_done", {31'd0, done}, 32'd0);
    rand_words(1);
    build();
    send_all();
    wait_done();
    check_load("over_reload", 1'b1);

    do_reset();
    rand_words(3);
    build();
    for (int i = 0; i < 8; i++) send_byte(bytes_q[i], 1'b0);
    chk("midrst_nwr_before", 32'(got_a.size()), 32'd1);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    rx = 1'b1;
    @(negedge clk);
    got_a.delete();
    got_d.delete();
    last_wr_cyc   = -1;
    done_rise_cyc = -1;
    rst_mis       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("midrst_nwr_after", 32'(got_a.size()), 32'd0);
    send_all();
    wait_done();
    check_load("midrst_reload", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
